// File: rtl/soda_payout_driver.sv
// Actuator sequencer for the vending dispense interface: product gate, then dimes, then nickel.
// Each actuation is a fixed pulse followed by an acknowledge wait with timeout into a sticky fault.
module soda_payout_driver #(
    parameter int unsigned PULSE_CYC   = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic dis,
    input  logic oN,
    input  logic oD,
    input  logic o2D,
    input  logic vend_ack,
    input  logic dime_ack,
    input  logic nick_ack,
    output logic vend_fire,
    output logic dime_fire,
    output logic nick_fire,
    output logic busy,
    output logic done,
    output logic overrun,
    output logic fault
);

    localparam int unsigned PW = $clog2(PULSE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, VEND_FIRE, VEND_WAIT, DIME_FIRE, DIME_WAIT, NICK_FIRE, NICK_WAIT, FAULT
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          vend_pend, vend_n;
    logic [1:0]    dime_cnt, dime_n;
    logic          nick_cnt, nick_n;
    logic          req, done_n, overrun_n;

    function automatic state_t pick(input logic v, input logic [1:0] d, input logic n);
        if (v)            return VEND_FIRE;
        else if (d != '0) return DIME_FIRE;
        else if (n)       return NICK_FIRE;
        else              return IDLE;
    endfunction

    assign req = dis | oN | oD | o2D;

    always_comb begin
        state_n   = state;
        pcnt_n    = pcnt;
        tcnt_n    = tcnt;
        vend_n    = vend_pend;
        dime_n    = dime_cnt;
        nick_n    = nick_cnt;
        overrun_n = req && (state != IDLE);
        unique case (state)
            IDLE: if (req) begin
                vend_n  = dis;
                dime_n  = {o2D, 1'b0} + {1'b0, oD};
                nick_n  = oN;
                state_n = pick(dis, {o2D, 1'b0} + {1'b0, oD}, oN);
            end
            VEND_FIRE, DIME_FIRE, NICK_FIRE: begin
                if (pcnt == PULSE_LAST) begin
                    case (state)
                        VEND_FIRE: state_n = VEND_WAIT;
                        DIME_FIRE: state_n = DIME_WAIT;
                        default:   state_n = NICK_WAIT;
                    endcase
                end else begin
                    pcnt_n = pcnt + PW'(1);
                end
            end
            VEND_WAIT, DIME_WAIT, NICK_WAIT: begin
                // An acknowledge on the expiry edge still counts as success.
                if (state == VEND_WAIT && vend_ack) begin
                    vend_n  = 1'b0;
                    state_n = pick(1'b0, dime_cnt, nick_cnt);
                end else if (state == DIME_WAIT && dime_ack) begin
                    dime_n  = dime_cnt - 2'd1;
                    state_n = pick(1'b0, dime_cnt - 2'd1, nick_cnt);
                end else if (state == NICK_WAIT && nick_ack) begin
                    nick_n  = 1'b0;
                    state_n = IDLE;
                end else if (tcnt == TIMEOUT_LAST) begin
                    state_n = FAULT;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            FAULT: state_n = FAULT;
            default: state_n = IDLE;
        endcase
        if (state_n != state) begin
            pcnt_n = '0;
            tcnt_n = '0;
        end
        done_n = (state != IDLE) && (state_n == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pcnt      <= '0;
            tcnt      <= '0;
            vend_pend <= 1'b0;
            dime_cnt  <= '0;
            nick_cnt  <= 1'b0;
            vend_fire <= 1'b0;
            dime_fire <= 1'b0;
            nick_fire <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            pcnt      <= pcnt_n;
            tcnt      <= tcnt_n;
            vend_pend <= vend_n;
            dime_cnt  <= dime_n;
            nick_cnt  <= nick_n;
            vend_fire <= (state_n == VEND_FIRE);
            dime_fire <= (state_n == DIME_FIRE);
            nick_fire <= (state_n == NICK_FIRE);
            busy      <= (state_n != IDLE);
            done      <= done_n;
            overrun   <= overrun_n;
            fault     <= (state_n == FAULT);
        end
    end

endmodule
